// File: rtl/fp_result_checker.sv
// fp_result_checker: consumes fp_unit results, pops one queued expected entry
// per result pulse, compares with quiet-NaN masking, and keeps pass/fail
// counters plus a capture of the first mismatching compare.
module fp_result_checker #(
   parameter int DEPTH       = 8,
   parameter int CNT_W       = 32,
   parameter bit STOP_ON_ERR = 1'b1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       exp_valid,
   input  logic [63:0]                exp_result,
   input  logic [4:0]                 exp_flags,
   input  logic [1:0]                 exp_fmt,
   input  logic                       exp_f2i,
   output logic                       exp_ready,
   input  logic                       res_valid,
   input  logic [63:0]                res_result,
   input  logic [4:0]                 res_flags,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [CNT_W-1:0]           pass_cnt,
   output logic [CNT_W-1:0]           fail_cnt,
   output logic                       error,
   output logic                       overflow,
   output logic                       underflow,
   output logic                       halted,
   output logic [CNT_W-1:0]           err_index,
   output logic [63:0]                err_exp_result,
   output logic [63:0]                err_calc_result,
   output logic [4:0]                 err_exp_flags,
   output logic [4:0]                 err_calc_flags
);

   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   // Handshake: a push is accepted when exp_valid && exp_ready in the same
   // cycle; exp_valid while exp_ready is low drops the entry and sets overflow.
   // A result pulse (res_valid) has no ready: it pops the head if one exists.
   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

   state_t             state;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;

   logic [63:0]        q_result [DEPTH];
   logic [4:0]         q_flags  [DEPTH];
   logic [1:0]         q_fmt    [DEPTH];
   logic               q_f2i    [DEPTH];

   logic               run;
   logic               empty;
   logic               full;
   logic               push;
   logic               pop;
   logic               pop_empty;
   logic [63:0]        head_result;
   logic [4:0]         head_flags;
   logic [1:0]         head_fmt;
   logic               head_f2i;
   logic [63:0]        diff;
   logic               mismatch;

   assign run       = (state == ST_RUN);
   assign empty     = (occupancy == '0);
   assign full      = (occupancy == OCC_W'(DEPTH));
   // Held low while reset is asserted so every output reads 0 during reset.
   assign exp_ready = !reset && !full && run;
   assign push      = exp_valid && exp_ready;
   assign pop       = res_valid && run && !empty;
   assign pop_empty = res_valid && run && empty;
   assign halted    = (state == ST_HALT);

   assign head_result = q_result[rd_ptr];
   assign head_flags  = q_flags[rd_ptr];
   assign head_fmt    = q_fmt[rd_ptr];
   assign head_f2i    = q_f2i[rd_ptr];

   // Compare head entry against the result; a canonical quiet NaN from the
   // unit only has to agree with the expected value on exponent+quiet bit.
   always_comb begin
      diff = res_result ^ head_result;
      if (head_fmt == 2'd0) begin
         if (!head_f2i && res_result[31:0] == 32'h7FC0_0000)
            diff = {55'd0, res_result[30:22] ^ head_result[30:22]};
      end else begin
         if (!head_f2i && res_result == 64'h7FF8_0000_0000_0000)
            diff = {52'd0, res_result[62:51] ^ head_result[62:51]};
      end
      mismatch = (diff != 64'd0) || (res_flags != head_flags);
   end

   // Queue storage; contents need no reset since occupancy guards reads.
   always_ff @(posedge clock) begin
      if (push) begin
         q_result[wr_ptr] <= exp_result;
         q_flags[wr_ptr]  <= exp_flags;
         q_fmt[wr_ptr]    <= exp_fmt;
         q_f2i[wr_ptr]    <= exp_f2i;
      end
   end

   // Control FSM, pointers, counters, sticky flags and first-mismatch capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= ST_RUN;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         occupancy       <= '0;
         pass_cnt        <= '0;
         fail_cnt        <= '0;
         error           <= 1'b0;
         overflow        <= 1'b0;
         underflow       <= 1'b0;
         err_index       <= '0;
         err_exp_result  <= '0;
         err_calc_result <= '0;
         err_exp_flags   <= '0;
         err_calc_flags  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      occupancy <= occupancy + OCC_W'(1);
         else if (pop && !push) occupancy <= occupancy - OCC_W'(1);
         if (exp_valid && !exp_ready) overflow  <= 1'b1;
         if (pop_empty)               underflow <= 1'b1;
         if (pop) begin
            if (mismatch) begin
               if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
               if (!error) begin
                  error           <= 1'b1;
                  err_index       <= pass_cnt + fail_cnt;
                  err_exp_result  <= head_result;
                  err_calc_result <= res_result;
                  err_exp_flags   <= head_flags;
                  err_calc_flags  <= res_flags;
               end
               if (STOP_ON_ERR) state <= ST_HALT;
            end else begin
               if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fp_result_checker.sv
// Directed bench for fp_result_checker: reset, compare masking, queue limits,
// underflow and halt-on-error behaviour.
module tb_fp_result_checker;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        exp_valid = 1'b0;
   logic [63:0] exp_result = '0;
   logic [4:0]  exp_flags = '0;
   logic [1:0]  exp_fmt = '0;
   logic        exp_f2i = 1'b0;
   logic        exp_ready;
   logic        res_valid = 1'b0;
   logic [63:0] res_result = '0;
   logic [4:0]  res_flags = '0;
   logic [3:0]  occupancy;
   logic [31:0] pass_cnt;
   logic [31:0] fail_cnt;
   logic        error;
   logic        overflow;
   logic        underflow;
   logic        halted;
   logic [31:0] err_index;
   logic [63:0] err_exp_result;
   logic [63:0] err_calc_result;
   logic [4:0]  err_exp_flags;
   logic [4:0]  err_calc_flags;

   int checks = 0;
   int errors = 0;

   fp_result_checker #(.DEPTH(8), .CNT_W(32), .STOP_ON_ERR(1'b1)) dut (
      .clock(clock), .reset(reset),
      .exp_valid(exp_valid), .exp_result(exp_result), .exp_flags(exp_flags),
      .exp_fmt(exp_fmt), .exp_f2i(exp_f2i), .exp_ready(exp_ready),
      .res_valid(res_valid), .res_result(res_result), .res_flags(res_flags),
      .occupancy(occupancy), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .error(error), .overflow(overflow), .underflow(underflow), .halted(halted),
      .err_index(err_index), .err_exp_result(err_exp_result),
      .err_calc_result(err_calc_result), .err_exp_flags(err_exp_flags),
      .err_calc_flags(err_calc_flags)
   );

   // Clock
   always #5 clock = ~clock;

   // Advance past the next rising edge; outputs are sampled here, inputs change here.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      exp_valid = 1'b0;
      res_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic push_entry(input logic [63:0] r, input logic [4:0] f,
                             input logic [1:0] fmt, input logic f2i);
      exp_valid = 1'b1; exp_result = r; exp_flags = f; exp_fmt = fmt; exp_f2i = f2i;
      tick();
      exp_valid = 1'b0;
   endtask

   task automatic send_result(input logic [63:0] r, input logic [4:0] f);
      res_valid = 1'b1; res_result = r; res_flags = f;
      tick();
      res_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset: got %b expected 0", exp_ready); end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
      checks++; if ({pass_cnt, fail_cnt, err_index} !== 96'd0) begin errors++; $display("FAIL reset_counters: got %h expected 0", {pass_cnt, fail_cnt, err_index}); end
      checks++; if ({error, overflow, underflow, halted} !== 4'd0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {error, overflow, underflow, halted}); end
      checks++; if ({err_exp_result, err_calc_result, err_exp_flags, err_calc_flags} !== 138'd0) begin errors++; $display("FAIL reset_capture: got nonzero expected 0"); end
      reset = 1'b0;
      #1;
      checks++; if (exp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", exp_ready); end
   endtask

   task automatic test_basic_pass();
      apply_reset();
      push_entry(64'h3F80_0000, 5'b00000, 2'd0, 1'b0);
      checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL basic_occ_push: got %0d expected 1", occupancy); end
      send_result(64'h3F80_0000, 5'b00000);
      checks++; if (pass_cnt !== 32'd1) begin errors++; $display("FAIL basic_pass_cnt: got %0d expected 1", pass_cnt); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error: got %b expected 0", error); end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL basic_occ_pop: got %0d expected 0", occupancy); end
   endtask

   task automatic test_nan_mask_single();
      apply_reset();
      push_entry(64'h7FC0_0001, 5'b00000, 2'd0, 1'b0);
      send_result(64'h7FC0_0000, 5'b00000);
      checks++; if (pass_cnt !== 32'd1 || fail_cnt !== 32'd0) begin errors++; $display("FAIL qnan_single_pass: got pass=%0d fail=%0d expected 1/0", pass_cnt, fail_cnt); end
      apply_reset();
      push_entry(64'h7FC0_0001, 5'b00000, 2'd0, 1'b1);
      send_result(64'h7FC0_0000, 5'b00000);
      checks++; if (fail_cnt !== 32'd1) begin errors++; $display("FAIL f2i_fail_cnt: got %0d expected 1", fail_cnt); end
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL f2i_error: got %b expected 1", error); end
      checks++; if (err_index !== 32'd0) begin errors++; $display("FAIL f2i_err_index: got %0d expected 0", err_index); end
      checks++; if (err_exp_result !== 64'h7FC0_0001) begin errors++; $display("FAIL f2i_err_exp: got %h expected 7fc00001", err_exp_result); end
      checks++; if (err_calc_result !== 64'h7FC0_0000) begin errors++; $display("FAIL f2i_err_calc: got %h expected 7fc00000", err_calc_result); end
      // Unmasked single compare must include the upper 32 bits.
      apply_reset();
      push_entry(64'h0000_0001_3F80_0000, 5'b00000, 2'd0, 1'b0);
      send_result(64'h0000_0000_3F80_0000, 5'b00000);
      checks++; if (fail_cnt !== 32'd1) begin errors++; $display("FAIL single_upper_bits: got fail=%0d expected 1", fail_cnt); end
   endtask

   task automatic test_nan_mask_double();
      apply_reset();
      push_entry(64'hFFF8_0000_0000_0001, 5'b00000, 2'd1, 1'b0);
      send_result(64'h7FF8_0000_0000_0000, 5'b00000);
      checks++; if (pass_cnt !== 32'd1 || fail_cnt !== 32'd0) begin errors++; $display("FAIL qnan_double_pass: got pass=%0d fail=%0d expected 1/0", pass_cnt, fail_cnt); end
      push_entry(64'hFFF8_0000_0000_0001, 5'b00000, 2'd1, 1'b0);
      send_result(64'h7FF8_0000_0000_0000, 5'b00001);
      checks++; if (fail_cnt !== 32'd1) begin errors++; $display("FAIL flags_fail_cnt: got %0d expected 1", fail_cnt); end
      checks++; if (err_index !== 32'd1) begin errors++; $display("FAIL flags_err_index: got %0d expected 1", err_index); end
      checks++; if (err_exp_flags !== 5'b00000 || err_calc_flags !== 5'b00001) begin errors++; $display("FAIL flags_capture: got exp=%b calc=%b expected 00000/00001", err_exp_flags, err_calc_flags); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      exp_valid = 1'b1; exp_flags = '0; exp_fmt = 2'd1; exp_f2i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_result = 64'h100 + 64'(i);
         tick();
      end
      exp_valid = 1'b0;
      checks++; if (occupancy !== 4'd8 || exp_ready !== 1'b0) begin errors++; $display("FAIL full_state: got occ=%0d ready=%b expected 8/0", occupancy, exp_ready); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf: got %b expected 0", overflow); end
      push_entry(64'h1FF, 5'b00000, 2'd1, 1'b0);
      checks++; if (overflow !== 1'b1 || occupancy !== 4'd8) begin errors++; $display("FAIL ovf_push: got ovf=%b occ=%0d expected 1/8", overflow, occupancy); end
      send_result(64'h100, 5'b00000);
      checks++; if (occupancy !== 4'd7 || pass_cnt !== 32'd1 || exp_ready !== 1'b1) begin errors++; $display("FAIL pop_from_full: got occ=%0d pass=%0d ready=%b expected 7/1/1", occupancy, pass_cnt, exp_ready); end
      exp_valid = 1'b1; exp_result = 64'h108;
      res_valid = 1'b1; res_result = 64'h101; res_flags = '0;
      tick();
      exp_valid = 1'b0;
      checks++; if (occupancy !== 4'd7 || pass_cnt !== 32'd2) begin errors++; $display("FAIL push_pop_same: got occ=%0d pass=%0d expected 7/2", occupancy, pass_cnt); end
      for (int i = 2; i < 9; i++) begin
         res_result = 64'h100 + 64'(i);
         tick();
      end
      res_valid = 1'b0;
      checks++; if (occupancy !== 4'd0 || pass_cnt !== 32'd9 || fail_cnt !== 32'd0) begin errors++; $display("FAIL drain: got occ=%0d pass=%0d fail=%0d expected 0/9/0", occupancy, pass_cnt, fail_cnt); end
      checks++; if (underflow !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL drain_flags: got unf=%b err=%b expected 0/0", underflow, error); end
   endtask

   task automatic test_underflow();
      apply_reset();
      send_result(64'h3F80_0000, 5'b00000);
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b expected 1", underflow); end
      checks++; if (pass_cnt !== 32'd0 || fail_cnt !== 32'd0) begin errors++; $display("FAIL underflow_counts: got pass=%0d fail=%0d expected 0/0", pass_cnt, fail_cnt); end
      checks++; if (halted !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL underflow_halt: got halted=%b err=%b expected 0/0", halted, error); end
   endtask

   task automatic test_halt();
      apply_reset();
      push_entry(64'h4000_0000, 5'b00000, 2'd0, 1'b0);
      push_entry(64'h4040_0000, 5'b00000, 2'd0, 1'b0);
      send_result(64'h4080_0000, 5'b00000);
      checks++; if (halted !== 1'b1 || fail_cnt !== 32'd1 || occupancy !== 4'd1) begin errors++; $display("FAIL halt_enter: got halted=%b fail=%0d occ=%0d expected 1/1/1", halted, fail_cnt, occupancy); end
      res_valid = 1'b1; res_result = 64'h4040_0000; res_flags = '0;
      for (int i = 0; i < 3; i++) tick();
      res_valid = 1'b0;
      checks++; if (fail_cnt !== 32'd1 || pass_cnt !== 32'd0 || occupancy !== 4'd1) begin errors++; $display("FAIL halt_frozen: got fail=%0d pass=%0d occ=%0d expected 1/0/1", fail_cnt, pass_cnt, occupancy); end
      checks++; if (underflow !== 1'b0 || exp_ready !== 1'b0) begin errors++; $display("FAIL halt_ready: got unf=%b ready=%b expected 0/0", underflow, exp_ready); end
      push_entry(64'h4100_0000, 5'b00000, 2'd0, 1'b0);
      checks++; if (overflow !== 1'b1 || occupancy !== 4'd1) begin errors++; $display("FAIL halt_push: got ovf=%b occ=%0d expected 1/1", overflow, occupancy); end
      reset = 1'b1;
      tick();
      checks++; if ({halted, error, overflow, occupancy, fail_cnt, err_exp_result} !== 103'd0) begin errors++; $display("FAIL halt_reset: got halted=%b err=%b ovf=%b occ=%0d fail=%0d expected all 0", halted, error, overflow, occupancy, fail_cnt); end
      reset = 1'b0;
      #1;
      checks++; if (exp_ready !== 1'b1) begin errors++; $display("FAIL halt_reset_ready: got %b expected 1", exp_ready); end
   endtask

   // Sequence of scenarios and final report
   initial begin
      test_reset();
      test_basic_pass();
      test_nan_mask_single();
      test_nan_mask_double();
      test_back_to_back();
      test_underflow();
      test_halt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
